stream_source: RTL and testbench
================================

// Module: stream_source
// PURPOSE
//  Valid/ready stream transmitter: emits a programmed burst of data beats into a
//  downstream valid/ready sink (typically a skid_buffer input), honouring backpressure.
//  Drives the upstream end of the same handshake skid_buffer accepts. Used as
//  a traffic source in benches and as an on-chip test-pattern generator.
// PARAMETERS
//  WIDTH    32  data beat width in bits (1..32 when STREAM_SOURCE_LFSR_EN defined)
//  LEN_W    16  width of burst length and beat counters
//  GAP_W     8  width of inter-beat gap counter
// PORTS
//  clk_i           in   1      clock; all logic on rising edge
//  clear_i         in   1      synchronous active-high reset
//  start_i         in   1      start a burst; sampled only in IDLE
//  burst_len_i     in   LEN_W  beats in burst; latched on accepted start
//  gap_i           in   GAP_W  idle cycles after each accepted beat; latched on start
//  first_i         in   WIDTH  first data value / seed; latched on start
//  busy_o          out  1      high in SEND and GAP
//  done_o          out  1      one-cycle pulse when burst complete
//  sent_count_o    out  LEN_W  beats accepted in current/last burst
//  output_valid_o  out  1      beat valid
//  output_ready_i  in   1      downstream ready
//  output_data_o   out  WIDTH  beat data
// BEHAVIOUR
//  - Reset (clear_i=1 at edge): state IDLE; output_valid_o=0, output_data_o=0,
//    busy_o=0, done_o=0, sent_count_o=0. clear_i wins over every other input, and
//    aborts a burst mid-flight (valid drops next cycle, no done pulse).
//  - Beat accepted on an edge where output_valid_o && output_ready_i.
//  - States IDLE, SEND, GAP:
//    IDLE: start_i && burst_len_i!=0 -> SEND; latch len/gap/first; sent_count_o<=0;
//          output_valid_o=1 and output_data_o=first_i from next cycle (latency 1).
//          start_i && burst_len_i==0 -> stay IDLE, done_o pulses next cycle,
//          sent_count_o<=0. start_i ignored outside IDLE.
//    SEND: output_valid_o=1. On acceptance: sent_count_o++, advance data.
//          Last beat accepted (count reaches len) -> IDLE, valid 0, done_o pulse
//          next cycle. Else gap==0 -> stay SEND (back-to-back, one beat/cycle at
//          full ready); gap!=0 -> GAP, valid 0.
//    GAP:  output_valid_o=0; count gap cycles, then -> SEND. Gap = exactly gap_i
//          cycles of valid low between acceptance and next valid.
//  - Protocol: once valid asserted, valid and data held stable until accepted;
//    valid never depends combinationally on output_ready_i. Outputs registered.
//  - Data: counting mode output_data_o = first + beat index, wraps mod 2^WIDTH.
//  - sent_count_o holds final value in IDLE until next accepted start.
//  - done_o and an IDLE start in same cycle: start honoured; done_o still pulses.
// CONFIGURATION
//  STREAM_SOURCE_LFSR_EN defined: data sequence is xorshift32 state
//    (s^=s<<13; s^=s>>17; s^=s<<5), seeded with zero-extended first_i (zero seed
//    replaced by 32'h1); first beat = seed, output_data_o = low WIDTH bits of state.
//  Undefined: counting mode only; no LFSR logic synthesised.
// TESTING
//  1 len=4 gap=0 first=0x10, ready=1 -> beats 0x10,0x11,0x12,0x13 on 4 consecutive
//    cycles, valid first seen 1 cycle after start, done_o 1 pulse, sent_count_o=4.
//  2 len=3 gap=2, ready=1 -> valid pattern 1,0,0,1,0,0,1; data 0,1,2; done pulse.
//  3 len=5, ready toggled random -> data/valid stable while ready=0, exactly 5
//    accepted beats in order, no beat lost or duplicated.
//  4 first=0xFFFF_FFFE len=3 -> 0xFFFF_FFFE,0xFFFF_FFFF,0x0000_0000 (wrap).
//  5 len=0 start -> no valid, done_o pulses next cycle, sent_count_o=0;
//    clear_i mid-burst after 2 beats -> valid 0 next cycle, no done, count 0.
//  6 LFSR_EN, first=0 -> first beat 0x0000_0001, second 0x0004_2021.

Source files
------------

// File: rtl/stream_source.sv
// Valid/ready burst transmitter: emits burst_len beats with optional inter-beat gaps.
// Define STREAM_SOURCE_LFSR_EN for an xorshift32 data sequence instead of counting data.
`timescale 1ns/1ps

module stream_source #(
  parameter int WIDTH = 32,
  parameter int LEN_W = 16,
  parameter int GAP_W = 8
) (
  input  logic             clk_i,
  input  logic             clear_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] burst_len_i,
  input  logic [GAP_W-1:0] gap_i,
  input  logic [WIDTH-1:0] first_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [LEN_W-1:0] sent_count_o,
  output logic             output_valid_o,
  input  logic             output_ready_i,
  output logic [WIDTH-1:0] output_data_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [LEN_W-1:0] len_q, len_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             done_q, done_d;

  logic             accept;
  logic [LEN_W-1:0] count_inc;
  logic             last_beat;
  logic             load_en;
  logic             adv_en;
  logic [WIDTH-1:0] first_beat;
  logic [WIDTH-1:0] next_beat;

  assign accept    = valid_q && output_ready_i;
  assign count_inc = count_q + LEN_W'(1);
  assign last_beat = (count_inc == len_q);
  assign load_en   = (state_q == ST_IDLE) && start_i && (burst_len_i != '0);
  assign adv_en    = (state_q == ST_SEND) && accept;

`ifdef STREAM_SOURCE_LFSR_EN
  logic [31:0] lfsr_q, lfsr_d;
  logic [31:0] seed;
  logic [31:0] lfsr_step;

  function automatic logic [31:0] xorshift32(input logic [31:0] s);
    logic [31:0] t;
    t = s ^ (s << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  // An all-zero state is a fixed point of xorshift, so a zero seed is replaced.
  assign seed       = (first_i == '0) ? 32'h1 : 32'(first_i);
  assign lfsr_step  = xorshift32(lfsr_q);
  assign first_beat = seed[WIDTH-1:0];
  assign next_beat  = lfsr_step[WIDTH-1:0];

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_en) begin
      lfsr_d = seed;
    end else if (adv_en) begin
      lfsr_d = lfsr_step;
    end
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      lfsr_q <= 32'h1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign first_beat = first_i;
  assign next_beat  = data_q + WIDTH'(1);
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (load_en) begin
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (accept) begin
          if (last_beat) begin
            state_d = ST_IDLE;
          end else if (gap_q != '0) begin
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q <= GAP_W'(1)) begin
          state_d = ST_SEND;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs plus the busy decode
  always_comb begin
    len_d     = len_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    count_d   = count_q;
    valid_d   = valid_q;
    data_d    = data_q;
    done_d    = 1'b0;
    busy_o    = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          count_d = '0;
          if (burst_len_i == '0) begin
            done_d = 1'b1;
          end else begin
            len_d   = burst_len_i;
            gap_d   = gap_i;
            valid_d = 1'b1;
            data_d  = first_beat;
          end
        end
      end
      ST_SEND: begin
        if (accept) begin
          count_d = count_inc;
          data_d  = next_beat;
          if (last_beat) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else if (gap_q != '0) begin
            valid_d   = 1'b0;
            gap_cnt_d = gap_q;
          end
        end
      end
      ST_GAP: begin
        // Valid rises on the edge that ends the last gap cycle.
        if (gap_cnt_q <= GAP_W'(1)) begin
          valid_d = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      default: begin
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      len_q     <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      len_q     <= len_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      done_q    <= done_d;
    end
  end

  assign done_o         = done_q;
  assign sent_count_o   = count_q;
  assign output_valid_o = valid_q;
  assign output_data_o  = data_q;

endmodule

// File: tb/tb_stream_source.sv
// Scoreboard bench for stream_source: a driver queues expected beats per burst,
// a negedge monitor checks every accepted beat, gap timing, stalls and done pulses.
`timescale 1ns/1ps

module tb_stream_source;
  localparam int WIDTH = 32;
  localparam int LEN_W = 16;
  localparam int GAP_W = 8;

  logic             clk = 1'b0;
  logic             clear_i = 1'b1;
  logic             start_i = 1'b0;
  logic [LEN_W-1:0] burst_len_i = '0;
  logic [GAP_W-1:0] gap_i = '0;
  logic [WIDTH-1:0] first_i = '0;
  logic             busy_o;
  logic             done_o;
  logic [LEN_W-1:0] sent_count_o;
  logic             output_valid_o;
  logic             output_ready_i = 1'b1;
  logic [WIDTH-1:0] output_data_o;

  always #5 clk = ~clk;

  stream_source #(.WIDTH(WIDTH), .LEN_W(LEN_W), .GAP_W(GAP_W)) dut (
    .clk_i          (clk),
    .clear_i        (clear_i),
    .start_i        (start_i),
    .burst_len_i    (burst_len_i),
    .gap_i          (gap_i),
    .first_i        (first_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .sent_count_o   (sent_count_o),
    .output_valid_o (output_valid_o),
    .output_ready_i (output_ready_i),
    .output_data_o  (output_data_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] exp_q[$];
  int               exp_done[$];
  int               cur_gap = 0;
  int               acc_total = 0;
  bit               ready_rand = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] xs32(input logic [31:0] s);
    logic [31:0] t;
    t = s ^ (s << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  // Reference: the idx-th beat of a burst started with value 'first'.
  function automatic logic [WIDTH-1:0] model_beat(input logic [WIDTH-1:0] first, input int idx);
`ifdef STREAM_SOURCE_LFSR_EN
    logic [31:0] s;
    s = (first == '0) ? 32'h1 : 32'(first);
    for (int i = 0; i < idx; i++) s = xs32(s);
    return s[WIDTH-1:0];
`else
    return first + WIDTH'(idx);
`endif
  endfunction

  task automatic drive_ready();
    output_ready_i = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input int len, input int gap, input logic [WIDTH-1:0] first);
    start_i     = 1'b1;
    burst_len_i = LEN_W'(len);
    gap_i       = GAP_W'(gap);
    first_i     = first;
    for (int i = 0; i < len; i++) exp_q.push_back(model_beat(first, i));
    exp_done.push_back(len);
    cur_gap = gap;
    drive_ready();
    tick();
    start_i     = 1'b0;
    burst_len_i = LEN_W'($urandom);
    gap_i       = GAP_W'($urandom);
    first_i     = WIDTH'($urandom);
    $display("burst start len=%0d gap=%0d first=0x%0h", len, gap, first);
    if (len != 0) begin
      check("first_valid_latency", output_valid_o, 1);
      check("first_data", output_data_o, model_beat(first, 0));
      check("busy_on_start", busy_o, 1);
    end else begin
      check("zero_len_no_valid", output_valid_o, 0);
      check("zero_len_done", done_o, 1);
      check("zero_len_count", sent_count_o, 0);
    end
    drive_ready();
  endtask

  // Runs until done_o is seen; leaves time at posedge+1 of the done cycle.
  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      if (done_o === 1'b1) begin
        seen = 1'b1;
      end else begin
        // start while busy must be ignored, as must changes on the latched inputs
        start_i     = busy_o && ($urandom_range(0, 3) == 0);
        burst_len_i = LEN_W'($urandom_range(0, 9));
        gap_i       = GAP_W'($urandom_range(0, 3));
        first_i     = WIDTH'($urandom);
        drive_ready();
        tick();
      end
    end
    start_i = 1'b0;
    check("done_seen", seen, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      output_ready_i = 1'b1;
      tick();
    end
  endtask

  // Monitor / scoreboard
  bit               prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data;
  bit               tracking = 1'b0;
  int               low_cnt = 0;
  int               burst_acc = 0;

  always @(negedge clk) begin
    if (clear_i) begin
      prev_stall = 1'b0;
      tracking   = 1'b0;
      burst_acc  = 0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", output_valid_o, 1);
        check("hold_data", output_data_o, prev_data);
      end
      if (done_o) begin
        tracking = 1'b0;
        if (exp_done.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: done_o high with no burst outstanding (t=%0t)", $time);
        end else begin
          int e;
          e = exp_done.pop_front();
          check("done_count", sent_count_o, e);
          check("done_beats", burst_acc, e);
          $display("done count=%0d beats=%0d", sent_count_o, burst_acc);
        end
        burst_acc = 0;
      end
      if (tracking && !output_valid_o) begin
        low_cnt++;
      end else if (tracking && output_valid_o) begin
        check("gap_cycles", low_cnt, cur_gap);
        tracking = 1'b0;
      end
      if (output_valid_o && output_ready_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: data 0x%0h with nothing expected (t=%0t)", output_data_o, $time);
        end else begin
          logic [WIDTH-1:0] e;
          e = exp_q.pop_front();
          check("beat_data", output_data_o, e);
          $display("beat data=0x%0h expected=0x%0h", output_data_o, e);
          burst_acc++;
          acc_total++;
          if (exp_q.size() != 0) begin
            tracking = 1'b1;
            low_cnt  = 0;
          end
        end
      end
      prev_stall = output_valid_o && !output_ready_i;
      prev_data  = output_data_o;
    end
  end

  initial begin
    int base;
    int len;
    // Reset
    idle(3);
    check("rst_valid", output_valid_o, 0);
    check("rst_data", output_data_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_count", sent_count_o, 0);
    clear_i = 1'b0;
    idle(2);

    // Back-to-back burst at full ready
    start_burst(4, 0, 32'h10);
    wait_done();
    idle(2);
    check("count_hold_4", sent_count_o, 4);
    check("busy_idle", busy_o, 0);

    // Gapped burst
    start_burst(3, 2, 32'h0);
    wait_done();
    idle(1);
    check("count_hold_3", sent_count_o, 3);

    // Random backpressure
    ready_rand = 1'b1;
    start_burst(5, 0, WIDTH'($urandom));
    wait_done();
    idle(1);
    check("count_hold_5", sent_count_o, 5);

    // Wrap around
    start_burst(3, 1, 32'hFFFF_FFFE);
    wait_done();
    ready_rand = 1'b0;
    idle(1);

    // Zero-length burst
    start_burst(0, 1, 32'h55);
    wait_done();
    idle(3);
    check("zero_len_count_hold", sent_count_o, 0);

`ifdef STREAM_SOURCE_LFSR_EN
    start_burst(2, 0, 32'h0);
    check("lfsr_zero_seed", output_data_o, 32'h1);
    wait_done();
    idle(1);
`endif

    // Start in the same cycle as done
    start_burst(3, 1, 32'h200);
    wait_done();
    start_burst(2, 0, 32'h300);
    wait_done();
    idle(1);
    check("count_hold_b2b", sent_count_o, 2);

    // Random bursts
    for (int r = 0; r < 10; r++) begin
      ready_rand = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 8);
      start_burst(len, $urandom_range(0, 3), WIDTH'($urandom));
      wait_done();
      idle(1);
      check("count_hold_rand", sent_count_o, len);
      check("busy_after_rand", busy_o, 0);
      idle($urandom_range(0, 2));
    end
    ready_rand = 1'b0;

    // Clear mid-burst after two accepted beats
    start_burst(6, 0, 32'hA0);
    base = acc_total - (acc_total > 0 ? 0 : 0);
    base = acc_total;
    for (int k = 0; k < 50 && (acc_total - base) < 1; k++) tick();
    for (int k = 0; k < 50 && (acc_total - base) < 2; k++) tick();
    check("clear_after_two", acc_total - base, 2);
    clear_i = 1'b1;
    exp_q.delete();
    exp_done.delete();
    tick();
    check("clear_valid", output_valid_o, 0);
    check("clear_done", done_o, 0);
    check("clear_count", sent_count_o, 0);
    check("clear_busy", busy_o, 0);
    clear_i = 1'b0;
    idle(6);
    check("clear_no_done", done_o, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
